// File: rtl/gf22_pad_pkg.sv
// Shared types for the GF22 pad bank controller: sequencer state encoding,
// attribute bit positions and the state-to-attribute decode.
package gf22_pad_pkg;

    typedef enum logic [2:0] {
        PWR_OFF     = 3'd0,
        PWR_UP_BIAS = 3'd1,
        PWR_UP_IO   = 3'd2,
        PWR_UP_CORE = 3'd3,
        PWR_READY   = 3'd4,
        PWR_DN_CORE = 3'd5,
        PWR_DN_IO   = 3'd6,
        PWR_DN_BIAS = 3'd7
    } pwr_state_e;

    localparam int ATTR_PWROK   = 0;
    localparam int ATTR_IOPWROK = 1;
    localparam int ATTR_BIAS    = 2;
    localparam int ATTR_USED    = 3;

    function automatic logic [ATTR_USED-1:0] attr_of(input pwr_state_e s);
        logic [ATTR_USED-1:0] a;
        a = '0;
        a[ATTR_BIAS]    = (s != PWR_OFF) && (s != PWR_DN_BIAS);
        a[ATTR_IOPWROK] = (s == PWR_UP_IO) || (s == PWR_UP_CORE) ||
                          (s == PWR_READY) || (s == PWR_DN_CORE);
        a[ATTR_PWROK]   = (s == PWR_UP_CORE) || (s == PWR_READY);
        return a;
    endfunction

endpackage

// File: rtl/gf22_pad_turn_ctrl.sv
// Per-pad direction control: glitch-free turnaround of the output enable,
// registered output data and a receive synchroniser gated while driving.
module gf22_pad_turn_ctrl #(
    parameter int TURN_CYC    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic turn_en_i,
    input  logic dir_i,
    input  logic data_i,
    input  logic pad_rx_i,
    output logic dir_ack_o,
    output logic rx_o,
    output logic pad_oe_o,
    output logic pad_data_o
);

    localparam int TW = $clog2(TURN_CYC + 1);

    logic [TW-1:0]          turn_cnt_q, turn_cnt_d;
    logic                   applied_q, applied_d;
    logic                   oe_q, oe_d;
    logic                   data_q, data_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pending;

    assign pending = (turn_cnt_q != '0);

    // turn_en_i reflects the sequencer's next state, so leaving READY clears
    // everything on the same edge the state register changes.
    always_comb begin
        turn_cnt_d = turn_cnt_q;
        applied_d  = applied_q;
        oe_d       = oe_q;
        data_d     = data_i;
        sync_d     = {sync_q[SYNC_STAGES-2:0], pad_rx_i};
        if (!turn_en_i) begin
            turn_cnt_d = '0;
            applied_d  = 1'b0;
            oe_d       = 1'b0;
        end else if (pending) begin
            turn_cnt_d = turn_cnt_q - TW'(1);
            oe_d       = 1'b0;
            if (turn_cnt_q == TW'(1)) begin
                applied_d = dir_i;
                oe_d      = dir_i;
            end
        end else if (dir_i != applied_q) begin
            turn_cnt_d = TW'(TURN_CYC);
            oe_d       = 1'b0;
        end else begin
            oe_d = applied_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            turn_cnt_q <= '0;
            applied_q  <= 1'b0;
            oe_q       <= 1'b0;
            data_q     <= 1'b0;
            sync_q     <= '0;
        end else begin
            turn_cnt_q <= turn_cnt_d;
            applied_q  <= applied_d;
            oe_q       <= oe_d;
            data_q     <= data_d;
            sync_q     <= sync_d;
        end
    end

    assign pad_oe_o   = oe_q;
    assign pad_data_o = data_q;
    assign dir_ack_o  = (dir_i == applied_q) && !pending;
    assign rx_o       = sync_q[SYNC_STAGES-1] && !oe_q && !pending;

endmodule

// File: rtl/gf22_pad_bank_ctrl.sv
// GF22 GPIO pad bank controller: power sequencer driving the shared pad
// attributes, plus one direction/receive controller per pad.
module gf22_pad_bank_ctrl
    import gf22_pad_pkg::*;
#(
    parameter int NPADS       = 8,
    parameter int PADATTR     = 16,
    parameter int CNT_W       = 8,
    parameter int TURN_CYC    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pwr_req_i,
    input  logic [CNT_W-1:0]         dly_bias_i,
    input  logic [CNT_W-1:0]         dly_io_i,
    input  logic [CNT_W-1:0]         dly_core_i,
    output logic                     pwr_ready_o,
    output logic [2:0]               pwr_state_o,
    input  logic [NPADS-1:0]         dir_i,
    input  logic [NPADS-1:0]         data_i,
    output logic [NPADS-1:0]         dir_ack_o,
    output logic [NPADS-1:0]         rx_o,
    output logic [NPADS-1:0]         pad_oe_o,
    output logic [NPADS-1:0]         pad_data_o,
    input  logic [NPADS-1:0]         pad_rx_i,
    output logic [NPADS*PADATTR-1:0] pad_attributes_o
);

    pwr_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ATTR_USED-1:0] attr_q, attr_d;
    logic                 ready_q, ready_d;

    // Aborted power-ups jump to the down state whose rails match what is
    // already up; down sequences always run through to OFF.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PWR_OFF:     if (pwr_req_i) state_d = PWR_UP_BIAS;
            PWR_UP_BIAS: if (!pwr_req_i) state_d = PWR_DN_IO;
                         else if (cnt_q == '0) state_d = PWR_UP_IO;
            PWR_UP_IO:   if (!pwr_req_i) state_d = PWR_DN_CORE;
                         else if (cnt_q == '0) state_d = PWR_UP_CORE;
            PWR_UP_CORE: if (!pwr_req_i) state_d = PWR_DN_CORE;
                         else if (cnt_q == '0) state_d = PWR_READY;
            PWR_READY:   if (!pwr_req_i) state_d = PWR_DN_CORE;
            PWR_DN_CORE: if (cnt_q == '0) state_d = PWR_DN_IO;
            PWR_DN_IO:   if (cnt_q == '0) state_d = PWR_DN_BIAS;
            PWR_DN_BIAS: if (cnt_q == '0) state_d = PWR_OFF;
        endcase

        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                PWR_UP_BIAS, PWR_DN_BIAS: cnt_d = dly_bias_i;
                PWR_UP_IO,   PWR_DN_IO:   cnt_d = dly_io_i;
                PWR_UP_CORE, PWR_DN_CORE: cnt_d = dly_core_i;
                default:                  cnt_d = '0;
            endcase
        end

        attr_d  = attr_of(state_q);
        ready_d = (state_q == PWR_READY);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PWR_OFF;
            cnt_q   <= '0;
            attr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            attr_q  <= attr_d;
            ready_q <= ready_d;
        end
    end

    assign pwr_ready_o = ready_q;
    assign pwr_state_o = state_q;

    for (genvar k = 0; k < NPADS; k++) begin : g_pad
        assign pad_attributes_o[k*PADATTR +: PADATTR] = {{(PADATTR-ATTR_USED){1'b0}}, attr_q};

        gf22_pad_turn_ctrl #(
            .TURN_CYC    (TURN_CYC),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_turn (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .turn_en_i  (state_d == PWR_READY),
            .dir_i      (dir_i[k]),
            .data_i     (data_i[k]),
            .pad_rx_i   (pad_rx_i[k]),
            .dir_ack_o  (dir_ack_o[k]),
            .rx_o       (rx_o[k]),
            .pad_oe_o   (pad_oe_o[k]),
            .pad_data_o (pad_data_o[k])
        );
    end

endmodule
